// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: reservation station and issue scheduler for the single integer ALU.
module alu_rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int RS_WIDTH = 4,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 RoB_clear,
  input  logic                 ins_valid,
  input  logic [5:0]           ins_op,
  input  logic [31:0]          ins_vj,
  input  logic [31:0]          ins_vk,
  input  logic                 ins_qj_valid,
  input  logic                 ins_qk_valid,
  input  logic [ROB_WIDTH-1:0] ins_qj,
  input  logic [ROB_WIDTH-1:0] ins_qk,
  input  logic [31:0]          ins_imm,
  input  logic [ROB_WIDTH-1:0] ins_rob_id,
  output logic                 rs_full,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_lsb_tag,
  input  logic [31:0]          cdb_lsb_value,
  output logic [31:0]          alu_vj,
  output logic [31:0]          alu_vk,
  output logic [31:0]          alu_imm,
  output logic [5:0]           alu_op,
  output logic                 alu_waiting,
  input  logic                 alu_finish_rdy,
  input  logic [31:0]          alu_value,
  output logic                 res_valid,
  output logic [ROB_WIDTH-1:0] res_rob_id,
  output logic [31:0]          res_value
);
  logic [RS_SIZE-1:0] busy, qj_valid, qk_valid, ready;
  logic [5:0] op [RS_SIZE];
  logic [31:0] vj [RS_SIZE];
  logic [31:0] vk [RS_SIZE];
  logic [31:0] imm [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_id [RS_SIZE];
  logic [ROB_WIDTH-1:0] issue_tag, res_tag;
  logic [RS_WIDTH-1:0] free_idx, sel_idx;
  logic sel_found;
  assign ready = busy & ~qj_valid & ~qk_valid;
  assign sel_found = |ready;
  assign rs_full = &busy;
  assign res_valid = alu_finish_rdy & ~RoB_clear;
  assign res_rob_id = res_tag;
  assign res_value = alu_value;
  // Descending scan so the lowest index wins for both free slot and ready entry
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_WIDTH'(i);
      if (ready[i]) sel_idx = RS_WIDTH'(i);
    end
  end
  function automatic logic hit(input logic pend, input logic [ROB_WIDTH-1:0] q);
    return pend && ((res_valid && res_rob_id == q) || (cdb_lsb_valid && cdb_lsb_tag == q));
  endfunction
  function automatic logic [31:0] fwd(input logic [ROB_WIDTH-1:0] q);
    return (cdb_lsb_valid && cdb_lsb_tag == q) ? cdb_lsb_value : res_value;
  endfunction
  always_ff @(posedge clk_in) begin
    if (rst_in || RoB_clear) begin
      busy <= '0;
      alu_waiting <= 1'b0;
      issue_tag <= '0;
      res_tag <= '0;
      if (rst_in) begin
        alu_vj <= '0;
        alu_vk <= '0;
        alu_imm <= '0;
        alu_op <= '0;
      end
    end else if (rdy_in) begin
      res_tag <= issue_tag;
      alu_waiting <= sel_found;
      if (sel_found) begin
        alu_vj <= vj[sel_idx];
        alu_vk <= vk[sel_idx];
        alu_imm <= imm[sel_idx];
        alu_op <= op[sel_idx];
        issue_tag <= rob_id[sel_idx];
        busy[sel_idx] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && hit(qj_valid[i], qj[i])) begin
          vj[i] <= fwd(qj[i]);
          qj_valid[i] <= 1'b0;
        end
        if (busy[i] && hit(qk_valid[i], qk[i])) begin
          vk[i] <= fwd(qk[i]);
          qk_valid[i] <= 1'b0;
        end
      end
      // Slot chosen from registered busy, so an entry issued now cannot be refilled now
      if (ins_valid && !rs_full) begin
        busy[free_idx] <= 1'b1;
        op[free_idx] <= ins_op;
        imm[free_idx] <= ins_imm;
        rob_id[free_idx] <= ins_rob_id;
        qj[free_idx] <= ins_qj;
        qk[free_idx] <= ins_qk;
        vj[free_idx] <= hit(ins_qj_valid, ins_qj) ? fwd(ins_qj) : ins_vj;
        vk[free_idx] <= hit(ins_qk_valid, ins_qk) ? fwd(ins_qk) : ins_vk;
        qj_valid[free_idx] <= ins_qj_valid && !hit(ins_qj_valid, ins_qj);
        qk_valid[free_idx] <= ins_qk_valid && !hit(ins_qk_valid, ins_qk);
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: vectors, corner sequences and random traffic against a behavioural model.
module tb_alu_rs_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_in, rdy_in, RoB_clear, ins_valid, ins_qj_valid, ins_qk_valid, cdb_lsb_valid;
  logic rs_full, alu_waiting, res_valid;
  logic alu_finish_rdy = 1'b0;
  logic [31:0] alu_value = '0;
  logic [5:0] ins_op, alu_op;
  logic [31:0] ins_vj, ins_vk, ins_imm, cdb_lsb_value, alu_vj, alu_vk, alu_imm, res_value;
  logic [3:0] ins_qj, ins_qk, ins_rob_id, cdb_lsb_tag, res_rob_id;
  int n_chk = 0, n_fail = 0;
  bit cmp_en = 0;

  alu_rs_scheduler dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
    .ins_valid(ins_valid), .ins_op(ins_op), .ins_vj(ins_vj), .ins_vk(ins_vk),
    .ins_qj_valid(ins_qj_valid), .ins_qk_valid(ins_qk_valid), .ins_qj(ins_qj), .ins_qk(ins_qk),
    .ins_imm(ins_imm), .ins_rob_id(ins_rob_id), .rs_full(rs_full),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
    .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_op(alu_op), .alu_waiting(alu_waiting),
    .alu_finish_rdy(alu_finish_rdy), .alu_value(alu_value),
    .res_valid(res_valid), .res_rob_id(res_rob_id), .res_value(res_value)
  );

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, b, i);
    case (op)
      6'd0: return a + b;
      6'd1: return a + i;
      6'd2: return a - b;
      6'd3: return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // One-cycle ALU as seen by the scheduler
  always @(posedge clk)
    if (rst_in || RoB_clear) alu_finish_rdy <= 1'b0;
    else if (rdy_in) begin
      alu_finish_rdy <= alu_waiting;
      if (alu_waiting) alu_value <= alu_f(alu_op, alu_vj, alu_vk, alu_imm);
    end

  typedef struct {
    bit busy; bit [5:0] op; bit [31:0] vj, vk, imm; bit pj, pk; bit [3:0] qj, qk, rob;
  } ent_t;
  ent_t m[16];
  bit m_wait, m_fin;
  bit [31:0] m_vj, m_vk, m_imm, m_aval;
  bit [5:0] m_op;
  bit [3:0] m_itag, m_rtag;

  function automatic bit m_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 0;
    return 1;
  endfunction
  function automatic bit hit(bit rv, bit [3:0] rt, bit [3:0] q);
    return (rv && rt == q) || (cdb_lsb_valid && cdb_lsb_tag == q);
  endfunction
  function automatic bit [31:0] fval(bit [3:0] q, bit [31:0] rvl);
    return (cdb_lsb_valid && cdb_lsb_tag == q) ? cdb_lsb_value : rvl;
  endfunction

  function automatic void step();
    bit rv, full;
    bit [3:0] rt;
    bit [31:0] rvl;
    int sel, fr;
    rv = m_fin && !RoB_clear;
    rt = m_rtag;
    rvl = m_aval;
    if (rst_in || RoB_clear) begin
      foreach (m[i]) m[i].busy = 0;
      m_wait = 0; m_fin = 0; m_itag = 0; m_rtag = 0;
      if (rst_in) begin m_vj = 0; m_vk = 0; m_imm = 0; m_op = 0; end
      return;
    end
    if (!rdy_in) return;
    sel = -1; fr = -1; full = 1;
    for (int i = 0; i < 16; i++) begin
      if (sel < 0 && m[i].busy && !m[i].pj && !m[i].pk) sel = i;
      if (!m[i].busy) begin full = 0; if (fr < 0) fr = i; end
    end
    if (m_wait) m_aval = alu_f(m_op, m_vj, m_vk, m_imm);
    m_fin = m_wait;
    m_rtag = m_itag;
    m_wait = sel >= 0;
    if (sel >= 0) begin
      m_vj = m[sel].vj; m_vk = m[sel].vk; m_imm = m[sel].imm; m_op = m[sel].op;
      m_itag = m[sel].rob; m[sel].busy = 0;
    end
    for (int i = 0; i < 16; i++) if (m[i].busy) begin
      if (m[i].pj && hit(rv, rt, m[i].qj)) begin m[i].vj = fval(m[i].qj, rvl); m[i].pj = 0; end
      if (m[i].pk && hit(rv, rt, m[i].qk)) begin m[i].vk = fval(m[i].qk, rvl); m[i].pk = 0; end
    end
    if (ins_valid && !full) begin
      m[fr] = '{1'b1, ins_op, ins_vj, ins_vk, ins_imm, ins_qj_valid, ins_qk_valid, ins_qj, ins_qk, ins_rob_id};
      if (ins_qj_valid && hit(rv, rt, ins_qj)) begin m[fr].pj = 0; m[fr].vj = fval(ins_qj, rvl); end
      if (ins_qk_valid && hit(rv, rt, ins_qk)) begin m[fr].pk = 0; m[fr].vk = fval(ins_qk, rvl); end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    #1;
    if (cmp_en) begin
      chk("model rs_full", rs_full, m_full());
      chk("model alu_waiting", alu_waiting, m_wait);
      chk("model alu_vj", alu_vj, m_vj);
      chk("model alu_vk", alu_vk, m_vk);
      chk("model alu_imm", alu_imm, m_imm);
      chk("model alu_op", alu_op, m_op);
      chk("model res_valid", res_valid, m_fin && !RoB_clear);
      chk("model res_rob_id", res_rob_id, m_rtag);
      if (m_fin && !RoB_clear) chk("model res_value", res_value, m_aval);
    end
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] vj, vk, imm,
                     input logic pj, input logic [3:0] qj, input logic pk, input logic [3:0] qk,
                     input logic [3:0] rob);
    ins_valid = 1; ins_op = op; ins_vj = vj; ins_vk = vk; ins_imm = imm;
    ins_qj_valid = pj; ins_qj = qj; ins_qk_valid = pk; ins_qk = qk; ins_rob_id = rob;
  endtask
  task automatic quiet();
    ins_valid = 0; cdb_lsb_valid = 0;
  endtask
  task automatic idle(input int n);
    quiet();
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic [5:0] op; logic [31:0] vj, vk, imm; logic [3:0] rob; logic [31:0] res;
  } vec_t;
  vec_t vt[6];

  initial begin
    bit s_wait, s_rv, s_full;
    bit [31:0] s_vj;
    bit [3:0] s_rt;
    vt[0] = '{6'd1, 32'd5, 32'd0, 32'd7, 4'd3, 32'd12};
    vt[1] = '{6'd0, 32'd100, 32'd23, 32'd0, 4'd7, 32'd123};
    vt[2] = '{6'd2, 32'd10, 32'd3, 32'd0, 4'd15, 32'd7};
    vt[3] = '{6'd3, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 4'd0, 32'hF0F0F0F0};
    vt[4] = '{6'd9, 32'hFFFFFFFF, 32'h12345678, 32'd1, 4'd8, 32'h12345678};
    vt[5] = '{6'd2, 32'd0, 32'd1, 32'd0, 4'd1, 32'hFFFFFFFF};
    rst_in = 1; rdy_in = 1; RoB_clear = 0; cdb_lsb_tag = 0; cdb_lsb_value = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet();
    tick(); tick();
    rst_in = 0; cmp_en = 1;
    chk("reset rs_full", rs_full, 0);
    chk("reset alu_waiting", alu_waiting, 0);
    chk("reset alu_vj", alu_vj, 0);
    chk("reset alu_imm", alu_imm, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_rob_id", res_rob_id, 0);

    foreach (vt[v]) begin
      put(vt[v].op, vt[v].vj, vt[v].vk, vt[v].imm, 0, 0, 0, 0, vt[v].rob);
      tick(); quiet();
      chk("vec waiting E0", alu_waiting, 0);
      tick();
      chk("vec waiting E1", alu_waiting, 1);
      chk("vec alu_vj", alu_vj, vt[v].vj);
      chk("vec alu_vk", alu_vk, vt[v].vk);
      chk("vec alu_imm", alu_imm, vt[v].imm);
      chk("vec alu_op", alu_op, vt[v].op);
      tick();
      chk("vec res_valid E2", res_valid, 1);
      chk("vec res_rob_id", res_rob_id, vt[v].rob);
      chk("vec res_value", res_value, vt[v].res);
      tick();
      chk("vec res_valid E3", res_valid, 0);
    end

    // Pending A, ready B, then LSB wakes A
    put(0, 0, 1, 0, 1, 2, 0, 0, 4); tick();
    put(0, 3, 4, 0, 0, 0, 0, 0, 5); tick();
    quiet(); cdb_lsb_valid = 1; cdb_lsb_tag = 2; cdb_lsb_value = 32'h10; tick();
    cdb_lsb_valid = 0;
    chk("lsb B issues first", alu_vj, 3);
    chk("lsb B waiting", alu_waiting, 1);
    tick();
    chk("lsb A waiting", alu_waiting, 1);
    chk("lsb A vj", alu_vj, 32'h10);
    chk("lsb A vk", alu_vk, 1);
    idle(4);

    // Dependency through the ALU CDB
    put(0, 1, 2, 0, 0, 0, 0, 0, 1); tick();
    put(0, 0, 10, 0, 1, 1, 0, 0, 2); tick(); quiet();
    chk("dep rob1 vj", alu_vj, 1);
    tick();
    chk("dep rob1 res_valid", res_valid, 1);
    chk("dep rob1 res_rob_id", res_rob_id, 1);
    chk("dep rob1 value", res_value, 3);
    tick();
    chk("dep wake no issue", alu_waiting, 0);
    tick();
    chk("dep rob2 waiting", alu_waiting, 1);
    chk("dep rob2 vj", alu_vj, 3);
    tick();
    chk("dep rob2 res_rob_id", res_rob_id, 2);
    chk("dep rob2 value", res_value, 13);
    idle(3);

    // Fill every entry, overflow insert, then free one slot
    for (int i = 0; i < 16; i++) begin
      put(0, 0, i, 0, 1, 4'(i), 0, 0, 4'(i));
      tick();
      if (i == 14) chk("fill 15 not full", rs_full, 0);
    end
    chk("fill 16 full", rs_full, 1);
    put(0, 1, 1, 0, 0, 0, 0, 0, 5); tick(); quiet();
    chk("overflow ignored waiting", alu_waiting, 0);
    tick();
    chk("overflow no issue", alu_waiting, 0);
    chk("overflow still full", rs_full, 1);
    cdb_lsb_valid = 1; cdb_lsb_tag = 0; cdb_lsb_value = 32'h55; tick(); quiet();
    chk("wake edge still full", rs_full, 1);
    chk("wake edge no issue", alu_waiting, 0);
    tick();
    chk("issue frees full", rs_full, 0);
    chk("issue woken", alu_waiting, 1);
    chk("issue woken vj", alu_vj, 32'h55);
    RoB_clear = 1; tick(); RoB_clear = 0;
    chk("clear full", rs_full, 0);
    chk("clear waiting", alu_waiting, 0);
    idle(3);

    // Flush with busy entries and an op in flight
    for (int i = 0; i < 4; i++) begin put(0, 0, 0, 0, 1, 12, 0, 0, 4'(i)); tick(); end
    put(0, 2, 2, 0, 0, 0, 0, 0, 9); tick(); quiet(); tick();
    chk("flush pre waiting", alu_waiting, 1);
    RoB_clear = 1; tick(); RoB_clear = 0;
    chk("flush rs_full", rs_full, 0);
    chk("flush waiting", alu_waiting, 0);
    chk("flush res_valid", res_valid, 0);
    cdb_lsb_valid = 1; cdb_lsb_tag = 12; cdb_lsb_value = 1; tick(); quiet();
    chk("flush res_valid 2", res_valid, 0);
    tick();
    chk("flush no issue", alu_waiting, 0);
    chk("flush res_valid 3", res_valid, 0);
    idle(2);

    // Stall mid-stream
    for (int i = 1; i <= 4; i++) begin put(0, i, 10 * i, 0, 0, 0, 0, 0, 4'(i)); tick(); end
    s_wait = m_wait; s_vj = m_vj; s_rv = m_fin; s_rt = m_rtag; s_full = m_full();
    rdy_in = 0;
    put(0, 9, 9, 0, 0, 0, 0, 0, 7);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall waiting", alu_waiting, s_wait);
      chk("stall alu_vj", alu_vj, s_vj);
      chk("stall res_valid", res_valid, s_rv);
      chk("stall res_rob_id", res_rob_id, s_rt);
      chk("stall rs_full", rs_full, s_full);
    end
    rdy_in = 1;
    idle(8);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      RoB_clear = ($urandom_range(0, 79) == 0);
      ins_valid = !m_full() && $urandom_range(0, 1);
      ins_op = 6'($urandom_range(0, 5));
      ins_vj = $urandom; ins_vk = $urandom; ins_imm = $urandom;
      ins_qj_valid = ($urandom_range(0, 2) == 0); ins_qj = 4'($urandom);
      ins_qk_valid = ($urandom_range(0, 3) == 0); ins_qk = 4'($urandom);
      ins_rob_id = 4'($urandom);
      cdb_lsb_valid = ($urandom_range(0, 2) == 0);
      cdb_lsb_tag = 4'($urandom);
      if (m_fin && cdb_lsb_tag == m_rtag) cdb_lsb_tag = cdb_lsb_tag + 4'd1;
      cdb_lsb_value = $urandom;
      tick();
    end
    RoB_clear = 0; rdy_in = 1;
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
